// File: rtl/alu_mc.sv
// Registered WIDTH-bit ALU for the MIPS EX stage: single-cycle logic/arith/compare ops plus
// iterative MULTU (shift-add) and DIVU (restoring) that deliver {result_hi, result_lo}.
module alu_mc #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             carry,
    output logic             ovf,
    output logic             dz,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state_dbg
);
    // Handshake: a request is taken on any edge with start=1 and busy=0 (no queueing while
    // busy); done pulses for one cycle when results land and is never high together with busy.
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             is_div;
    logic [WIDTH-1:0] work_hi, work_lo, opnd;

    logic             accept, multi;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] sc_lo;
    logic             sc_carry, sc_ovf;

    assign accept    = start && !busy;
    assign multi     = (op[3:1] == 3'b101);
    assign b_eff     = op[2] ? ~b : b;
    assign sum       = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, op[2]};
    assign state_dbg = state;

    always_comb begin
        sc_lo    = '0;
        sc_carry = 1'b0;
        sc_ovf   = 1'b0;
        if (!op[3]) begin
            case (op[1:0])
                2'b00: sc_lo = a & b_eff;
                2'b01: sc_lo = a | b_eff;
                2'b10: begin
                    sc_lo    = sum[WIDTH-1:0];
                    sc_carry = sum[WIDTH];
                    sc_ovf   = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
                end
                default: sc_lo = a ^ b_eff;
            endcase
        end else begin
            case (op[2:0])
                3'b000:  sc_lo = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
                3'b001:  sc_lo = {{(WIDTH-1){1'b0}}, (a < b)};
                default: sc_lo = '0;
            endcase
        end
    end

    // One iteration step; work_lo holds the multiplier (MULTU) or the dividend (DIVU) and
    // is shifted out while the product high half / partial remainder builds up in work_hi.
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_part;
    logic [WIDTH-1:0] div_diff;
    logic             div_ok;
    logic [WIDTH-1:0] next_hi, next_lo;

    assign mul_sum  = {1'b0, work_hi} + (work_lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    assign div_part = {work_hi, work_lo[WIDTH-1]};
    assign div_ok   = (div_part >= {1'b0, opnd});
    assign div_diff = div_part[WIDTH-1:0] - opnd;
    assign next_hi  = is_div ? (div_ok ? div_diff : div_part[WIDTH-1:0]) : mul_sum[WIDTH:1];
    assign next_lo  = is_div ? {work_lo[WIDTH-2:0], div_ok} : {mul_sum[0], work_lo[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            is_div    <= 1'b0;
            work_hi   <= '0;
            work_lo   <= '0;
            opnd      <= '0;
            result_lo <= '0;
            result_hi <= '0;
            zero      <= 1'b0;
            carry     <= 1'b0;
            ovf       <= 1'b0;
            dz        <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (accept && multi) begin
                        state     <= RUN;
                        busy      <= 1'b1;
                        cnt       <= '0;
                        is_div    <= op[0];
                        work_hi   <= '0;
                        work_lo   <= a;
                        opnd      <= b;
                        result_lo <= '0;
                        result_hi <= '0;
                        zero      <= 1'b0;
                        carry     <= 1'b0;
                        ovf       <= 1'b0;
                        dz        <= 1'b0;
                    end else if (accept) begin
                        state     <= DONE;
                        done      <= 1'b1;
                        result_lo <= sc_lo;
                        result_hi <= '0;
                        zero      <= (sc_lo == '0);
                        carry     <= sc_carry;
                        ovf       <= sc_ovf;
                        dz        <= 1'b0;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    work_hi <= next_hi;
                    work_lo <= next_lo;
                    cnt     <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        result_hi <= next_hi;
                        result_lo <= next_lo;
                        zero      <= (next_lo == '0);
                        dz        <= is_div && (opnd == '0);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc at WIDTH=32 and WIDTH=8: directed vectors, arithmetic reference model,
// per-cycle compare of handshake and outputs.
module tb_alu_mc;
  localparam logic [3:0] OP_AND = 4'b0000, OP_OR = 4'b0001, OP_ADD = 4'b0010, OP_XOR = 4'b0011;
  localparam logic [3:0] OP_ANDN = 4'b0100, OP_ORN = 4'b0101, OP_SUB = 4'b0110, OP_XNOR = 4'b0111;
  localparam logic [3:0] OP_SLT = 4'b1000, OP_SLTU = 4'b1001, OP_MULTU = 4'b1010, OP_DIVU = 4'b1011;

  typedef struct {
    int          due;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        zero;
    logic        carry;
    logic        ovf;
    logic        dz;
  } exp_t;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        start32, start8;
  logic [3:0]  op32, op8;
  logic [31:0] a32, b32, lo32, hi32;
  logic [7:0]  a8, b8, lo8, hi8;
  logic        zero32, carry32, ovf32, dz32, busy32, done32;
  logic        zero8, carry8, ovf8, dz8, busy8, done8;
  logic [1:0]  st32, st8;

  alu_mc #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .op(op32), .a(a32), .b(b32),
    .result_lo(lo32), .result_hi(hi32), .zero(zero32), .carry(carry32), .ovf(ovf32),
    .dz(dz32), .busy(busy32), .done(done32), .state_dbg(st32)
  );

  alu_mc #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .op(op8), .a(a8), .b(b8),
    .result_lo(lo8), .result_hi(hi8), .zero(zero8), .carry(carry8), .ovf(ovf8),
    .dz(dz8), .busy(busy8), .done(done8), .state_dbg(st8)
  );

  // scoreboard state
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   cmp_en = 1'b0;
  exp_t exp_q0[$];
  exp_t exp_q1[$];
  exp_t held[2];
  int   bfrom[2];
  int   bto[2];

  task automatic chk(input string name, input int d, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d cyc=%0d got=%h expected=%h", name, d, cyc, got, exp);
    end
  endtask

  function automatic exp_t zero_exp();
    exp_t e;
    e.due = 0; e.lo = '0; e.hi = '0; e.zero = 1'b0; e.carry = 1'b0; e.ovf = 1'b0; e.dz = 1'b0;
    return e;
  endfunction

  // Reference model: plain integer arithmetic on w-bit values.
  function automatic exp_t model(input int w, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [63:0] mask, ua, ub, nb, beff, r;
    longint sa, sb, s, smax, smin;
    e = zero_exp();
    mask = (64'd1 << w) - 64'd1;
    ua = {32'd0, a} & mask;
    ub = {32'd0, b} & mask;
    nb = ~ub & mask;
    beff = op[2] ? nb : ub;
    sa = ua[w-1] ? longint'(ua) - (longint'(1) << w) : longint'(ua);
    sb = ub[w-1] ? longint'(ub) - (longint'(1) << w) : longint'(ub);
    smax = (longint'(1) << (w - 1)) - 1;
    smin = -(longint'(1) << (w - 1));
    r = 64'd0;
    case (op)
      OP_AND, OP_ANDN: r = ua & beff;
      OP_OR, OP_ORN:   r = ua | beff;
      OP_XOR, OP_XNOR: r = ua ^ beff;
      OP_ADD: begin
        r = ua + ub;
        e.carry = (r > mask);
        s = sa + sb;
        e.ovf = (s > smax) || (s < smin);
      end
      OP_SUB: begin
        r = ua - ub;
        e.carry = (ua >= ub);
        s = sa - sb;
        e.ovf = (s > smax) || (s < smin);
      end
      OP_SLT:  r = {63'd0, (sa < sb)};
      OP_SLTU: r = {63'd0, (ua < ub)};
      OP_MULTU: begin
        r = ua * ub;
        e.hi = 32'((r >> w) & mask);
      end
      OP_DIVU: begin
        if (ub == 64'd0) begin
          r = mask;
          e.hi = 32'(ua);
          e.dz = 1'b1;
        end else begin
          r = ua / ub;
          e.hi = 32'(ua % ub);
        end
      end
      default: r = 64'd0;
    endcase
    e.lo = 32'(r & mask);
    e.zero = (e.lo == 32'd0);
    return e;
  endfunction

  // per-cycle compare, one DUT at a time
  task automatic check_dut(input int d);
    exp_t f;
    bit have;
    logic eb;
    logic [31:0] lo, hi;
    logic z, c, v, dv, bs, dn;
    if (d == 0) begin
      lo = lo32; hi = hi32; z = zero32; c = carry32; v = ovf32; dv = dz32; bs = busy32; dn = done32;
    end else begin
      lo = {24'd0, lo8}; hi = {24'd0, hi8}; z = zero8; c = carry8; v = ovf8; dv = dz8; bs = busy8; dn = done8;
    end
    eb = (cyc >= bfrom[d]) && (cyc <= bto[d]);
    chk("busy", d, {31'd0, bs}, {31'd0, eb});
    have = 1'b0;
    if (d == 0) begin
      while (exp_q0.size() > 0 && exp_q0[0].due < cyc) void'(exp_q0.pop_front());
      if (exp_q0.size() > 0 && exp_q0[0].due == cyc) begin f = exp_q0.pop_front(); have = 1'b1; end
    end else begin
      while (exp_q1.size() > 0 && exp_q1[0].due < cyc) void'(exp_q1.pop_front());
      if (exp_q1.size() > 0 && exp_q1[0].due == cyc) begin f = exp_q1.pop_front(); have = 1'b1; end
    end
    if (have) begin
      chk("done", d, {31'd0, dn}, 32'd1);
      held[d] = f;
    end else begin
      chk("done", d, {31'd0, dn}, 32'd0);
    end
    if (eb) begin
      chk("lo_run", d, lo, 32'd0);
      chk("hi_run", d, hi, 32'd0);
    end else begin
      chk("result_lo", d, lo, held[d].lo);
      chk("result_hi", d, hi, held[d].hi);
      chk("zero", d, {31'd0, z}, {31'd0, held[d].zero});
      chk("carry", d, {31'd0, c}, {31'd0, held[d].carry});
      chk("ovf", d, {31'd0, v}, {31'd0, held[d].ovf});
      chk("dz", d, {31'd0, dv}, {31'd0, held[d].dz});
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (cmp_en) begin
      check_dut(0);
      check_dut(1);
    end
  end

  // driver tasks (called at a negedge, return at the next negedge)
  task automatic issue(input int d, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input bit keep);
    exp_t e;
    int k, w;
    w = (d == 0) ? 32 : 8;
    k = cyc + 1;
    if (d == 0) begin start32 = 1'b1; op32 = op; a32 = a; b32 = b; end
    else begin start8 = 1'b1; op8 = op; a8 = a[7:0]; b8 = b[7:0]; end
    e = model(w, op, a, b);
    if (op == OP_MULTU || op == OP_DIVU) begin
      e.due = k + w; bfrom[d] = k; bto[d] = k + w - 1;
    end else begin
      e.due = k;
    end
    if (d == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
    @(negedge clk);
    if (!keep) begin
      if (d == 0) start32 = 1'b0; else start8 = 1'b0;
    end
  endtask

  task automatic poke(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    start32 = 1'b1; op32 = op; a32 = a; b32 = b;
    @(negedge clk);
    start32 = 1'b0; a32 = $urandom_range(32'hFFFF, 0); b32 = $urandom_range(32'hFFFF, 0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_done(input int d, input int limit);
    int left;
    left = (d == 0) ? exp_q0.size() : exp_q1.size();
    for (int i = 0; i < limit && left > 0; i++) begin
      @(negedge clk);
      left = (d == 0) ? exp_q0.size() : exp_q1.size();
    end
    chk("timeout", d, left, 32'd0);
    if (d == 0) exp_q0.delete(); else exp_q1.delete();
    @(negedge clk);
  endtask

  task automatic rst_pulse();
    rst_n = 1'b0;
    start32 = 1'b0;
    start8 = 1'b0;
    exp_q0.delete();
    exp_q1.delete();
    for (int d = 0; d < 2; d++) begin
      held[d] = zero_exp(); bfrom[d] = -1; bto[d] = -2;
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic pin(input string name, input logic [31:0] got, input logic [31:0] exp);
    chk(name, 0, got, exp);
  endtask

  initial begin
    exp_t m;
    rst_n = 1'b0; start32 = 1'b0; start8 = 1'b0;
    op32 = '0; a32 = '0; b32 = '0; op8 = '0; a8 = '0; b8 = '0;
    for (int d = 0; d < 2; d++) begin
      held[d] = zero_exp(); bfrom[d] = -1; bto[d] = -2;
    end

    // hand-computed pins of the model
    m = model(32, OP_ADD, 32'h7FFFFFFF, 32'd1);
    pin("pin_add_lo", m.lo, 32'h80000000); pin("pin_add_ovf", {31'd0, m.ovf}, 32'd1);
    pin("pin_add_carry", {31'd0, m.carry}, 32'd0);
    m = model(32, OP_SUB, 32'd5, 32'd5);
    pin("pin_sub_zero", {31'd0, m.zero}, 32'd1); pin("pin_sub_carry", {31'd0, m.carry}, 32'd1);
    m = model(32, OP_SLT, 32'hFFFFFFFF, 32'd1);  pin("pin_slt", m.lo, 32'd1);
    m = model(32, OP_SLTU, 32'hFFFFFFFF, 32'd1); pin("pin_sltu", m.lo, 32'd0);
    m = model(32, OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    pin("pin_mul_hi", m.hi, 32'hFFFFFFFE); pin("pin_mul_lo", m.lo, 32'h00000001);
    m = model(32, OP_DIVU, 32'd100, 32'd7);
    pin("pin_div_q", m.lo, 32'd14); pin("pin_div_r", m.hi, 32'd2);
    m = model(32, OP_DIVU, 32'h1234, 32'd0);
    pin("pin_dz_q", m.lo, 32'hFFFFFFFF); pin("pin_dz_r", m.hi, 32'h1234);
    m = model(8, OP_MULTU, 32'hFF, 32'hFF);
    pin("pin_mul8_hi", m.hi, 32'hFE); pin("pin_mul8_lo", m.lo, 32'h01);

    // reset state
    idle(2);
    chk("rst_lo", 0, lo32, 32'd0);
    chk("rst_hi", 0, hi32, 32'd0);
    chk("rst_flags", 0, {26'd0, zero32, carry32, ovf32, dz32, busy32, done32}, 32'd0);
    chk("rst_state", 0, {30'd0, st32}, 32'd0);
    chk("rst_flags", 1, {26'd0, zero8, carry8, ovf8, dz8, busy8, done8}, 32'd0);
    chk("rst_state", 1, {30'd0, st8}, 32'd0);
    rst_n = 1'b1;
    cmp_en = 1'b1;
    idle(1);

    // single-cycle ops
    issue(0, OP_ADD, 32'h7FFFFFFF, 32'd1, 1'b0);
    idle(2);
    issue(0, OP_SUB, 32'd5, 32'd5, 1'b0);
    issue(0, OP_SUB, 32'd3, 32'd5, 1'b0);
    issue(0, OP_SUB, 32'h80000000, 32'd1, 1'b0);
    issue(0, OP_ADD, 32'hFFFFFFFF, 32'd1, 1'b0);
    idle(1);
    issue(0, OP_AND, 32'hF0F0_1234, 32'hFF00_00FF, 1'b0);
    issue(0, OP_ANDN, 32'hF0F0_1234, 32'hFF00_00FF, 1'b0);
    issue(0, OP_ORN, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0);
    issue(0, OP_XNOR, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b0);
    issue(0, OP_SLT, 32'hFFFFFFFF, 32'd1, 1'b0);
    issue(0, OP_SLTU, 32'hFFFFFFFF, 32'd1, 1'b0);
    issue(0, OP_SLT, 32'd1, 32'hFFFFFFFF, 1'b0);
    issue(0, 4'b1100, 32'd9, 32'd9, 1'b0);
    issue(0, 4'b1111, 32'd1, 32'd2, 1'b0);
    idle(2);

    // multi-cycle ops
    issue(0, OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    wait_done(0, 40);
    issue(0, OP_DIVU, 32'd100, 32'd7, 1'b0);
    wait_done(0, 40);
    issue(0, OP_DIVU, 32'h1234, 32'd0, 1'b0);
    wait_done(0, 40);
    issue(0, OP_DIVU, 32'd7, 32'd100, 1'b0);
    wait_done(0, 40);
    issue(0, OP_MULTU, 32'd0, 32'h1234_5678, 1'b0);
    wait_done(0, 40);

    // start while busy is ignored, then a held start streams single-cycle ops
    issue(0, OP_MULTU, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
    idle(5);
    poke(OP_ADD, 32'd2, 32'd3);
    idle(3);
    poke(OP_ADD, 32'd4, 32'd4);
    wait_done(0, 40);
    issue(0, OP_AND, 32'hFFFF_0000, 32'h0F0F_0F0F, 1'b1);
    issue(0, OP_OR, 32'hFFFF_0000, 32'h0F0F_0F0F, 1'b1);
    issue(0, OP_XOR, 32'hFFFF_0000, 32'h0F0F_0F0F, 1'b0);
    idle(2);

    // reset in the middle of a divide, then a fresh add
    issue(0, OP_DIVU, 32'hFFFFFFFF, 32'd3, 1'b0);
    idle(9);
    rst_pulse();
    idle(2);
    issue(0, OP_ADD, 32'd2, 32'd3, 1'b0);
    idle(2);

    // WIDTH = 8 instance
    issue(1, OP_MULTU, 32'hFF, 32'hFF, 1'b0);
    wait_done(1, 20);
    issue(1, OP_DIVU, 32'd200, 32'd7, 1'b0);
    wait_done(1, 20);
    issue(1, OP_DIVU, 32'h5A, 32'd0, 1'b0);
    wait_done(1, 20);
    issue(1, OP_ADD, 32'h7F, 32'd1, 1'b0);
    issue(1, OP_SUB, 32'd0, 32'd1, 1'b0);
    issue(1, OP_SLT, 32'h80, 32'h7F, 1'b0);
    idle(2);
    wait_done(0, 5);
    wait_done(1, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
